// File: rtl/controlo_barreira_seq.sv
// controlo_barreira_seq: serial plate reader with format/day check, timed barrier cycle
// and car-park occupancy tracking.
module controlo_barreira_seq #(
  parameter int               N_DIG       = 6,
  parameter logic [N_DIG-1:0] LETTER_MASK = 6'b000100,
  parameter int               OPEN_CYC    = 16,
  parameter int               CAPACITY    = 8,
  parameter int               CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dig_valid_i,
  input  logic [3:0]       dig_i,
  input  logic [2:0]       dia_i,
  input  logic             car_passed_i,
  input  logic             car_exit_i,
  output logic             ready_o,
  output logic             matr_val_o,
  output logic             barreira_o,
  output logic             rejeitado_o,
  output logic [CNT_W-1:0] ocupacao_o,
  output logic             cheio_o
);
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int TW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
  typedef enum logic [1:0] {IDLE, CHECK, OPEN, REJ} state_t;
  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [TW-1:0]    timer_q;
  logic [3:0]       chars_q [N_DIG];
  logic             matr_val_q, barreira_q, rejeitado_q;
  logic [CNT_W-1:0] ocupacao_q, ocupacao_d;
  logic             fmt_ok, day_ok, cheio, inc, dec;
  always_comb begin
    fmt_ok = 1'b1;
    for (int i = 0; i < N_DIG; i++)
      fmt_ok = fmt_ok & (LETTER_MASK[i] ? (chars_q[i] >= 4'd10) : (chars_q[i] <= 4'd9));
  end
  // Odd days admit odd last digits, even days even ones; day 7 admits all.
  assign day_ok = (dia_i == 3'd7) | ((dia_i != 3'd0) & (dia_i[0] == chars_q[N_DIG-1][0]));
  assign cheio  = ocupacao_q == CNT_W'(CAPACITY);
  assign inc    = (state_q == OPEN) & car_passed_i;
  // An exit paired with an entry always nets to zero; a lone exit at zero is dropped.
  assign dec        = car_exit_i & ((ocupacao_q != '0) | inc);
  assign ocupacao_d = ocupacao_q + CNT_W'(inc) - CNT_W'(dec);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      matr_val_q  <= 1'b0;
      barreira_q  <= 1'b0;
      rejeitado_q <= 1'b0;
      ocupacao_q  <= '0;
      for (int i = 0; i < N_DIG; i++) chars_q[i] <= '0;
    end else begin
      ocupacao_q  <= ocupacao_d;
      rejeitado_q <= 1'b0;
      case (state_q)
        IDLE: if (dig_valid_i) begin
          chars_q[idx_q] <= dig_i;
          if (idx_q == IW'(N_DIG - 1)) begin
            idx_q   <= '0;
            state_q <= CHECK;
          end else idx_q <= idx_q + 1'b1;
        end
        CHECK: begin
          matr_val_q <= fmt_ok;
          if (fmt_ok & day_ok & !cheio) begin
            state_q    <= OPEN;
            barreira_q <= 1'b1;
            timer_q    <= '0;
          end else begin
            state_q     <= REJ;
            rejeitado_q <= 1'b1;
          end
        end
        // A pass on the final timer cycle still counts as an entry via inc.
        OPEN: if (car_passed_i || timer_q == TW'(OPEN_CYC - 1)) begin
          barreira_q <= 1'b0;
          state_q    <= IDLE;
        end else timer_q <= timer_q + 1'b1;
        REJ: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ready_o     = state_q == IDLE;
  assign matr_val_o  = matr_val_q;
  assign barreira_o  = barreira_q;
  assign rejeitado_o = rejeitado_q;
  assign ocupacao_o  = ocupacao_q;
  assign cheio_o     = cheio;
endmodule

// File: tb/tb_controlo_barreira_seq.sv
// tb_controlo_barreira_seq: directed checks of plate admission, barrier timing and occupancy.
module tb_controlo_barreira_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dig_valid = 1'b0;
  logic [3:0] dig = '0;
  logic [2:0] dia = '0;
  logic       car_passed = 1'b0;
  logic       car_exit = 1'b0;
  logic       ready, matr_val, barreira, rejeitado, cheio;
  logic [3:0] ocupacao;
  int         n_chk = 0;
  int         n_fail = 0;
  int         open_cnt;
  controlo_barreira_seq dut (
    .clk(clk), .rst_n(rst_n), .dig_valid_i(dig_valid), .dig_i(dig), .dia_i(dia),
    .car_passed_i(car_passed), .car_exit_i(car_exit), .ready_o(ready),
    .matr_val_o(matr_val), .barreira_o(barreira), .rejeitado_o(rejeitado),
    .ocupacao_o(ocupacao), .cheio_o(cheio)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Sends six chars, first char in the top nibble; returns on the CHECK cycle.
  task automatic send(input logic [23:0] p, input logic [2:0] d);
    dia = d;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dig_valid = 1'b1;
      dig = p[23-4*i -: 4];
    end
    @(negedge clk);
    dig_valid = 1'b0;
  endtask
  task automatic admit_pass;
    send(24'h34A366, 3'd7);
    @(negedge clk);
    car_passed = 1'b1;
    @(negedge clk);
    car_passed = 1'b0;
  endtask
  task automatic expect_reject(input string tag, input logic mv);
    @(negedge clk);
    chk({tag, "_rej"}, rejeitado, 1);
    chk({tag, "_bar"}, barreira, 0);
    chk({tag, "_mv"}, matr_val, mv);
    @(negedge clk);
    chk({tag, "_rej_end"}, rejeitado, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_mv", matr_val, 0);
    chk("rst_bar", barreira, 0);
    chk("rst_rej", rejeitado, 0);
    chk("rst_occ", ocupacao, 0);
    chk("rst_cheio", cheio, 0);
    rst_n = 1'b1;
    send(24'h34A366, 3'd2);
    chk("check_ready", ready, 0);
    chk("check_bar", barreira, 0);
    @(negedge clk);
    chk("open_bar", barreira, 1);
    chk("open_mv", matr_val, 1);
    car_passed = 1'b1;
    @(negedge clk);
    car_passed = 1'b0;
    chk("pass_bar", barreira, 0);
    chk("pass_occ", ocupacao, 1);
    chk("pass_ready", ready, 1);
    send(24'h34A366, 3'd1);
    expect_reject("odd_day", 1);
    send(24'hBBABFF, 3'd4);
    expect_reject("fmt_b", 0);
    send(24'hBBABFF, 3'd7);
    expect_reject("fmt_b_free", 0);
    send(24'h123468, 3'd3);
    expect_reject("no_letter", 0);
    send(24'h34A366, 3'd0);
    expect_reject("dia0", 1);
    chk("rej_occ", ocupacao, 1);
    send(24'h34A366, 3'd7);
    open_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      open_cnt += int'(barreira);
    end
    chk("timeout_len", open_cnt, 16);
    chk("timeout_occ", ocupacao, 1);
    chk("timeout_ready", ready, 1);
    send(24'h34A366, 3'd7);
    @(negedge clk);
    chk("pre_rst_bar", barreira, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bar", barreira, 0);
    chk("async_occ", ocupacao, 0);
    chk("async_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    send(24'h34A366, 3'd7);
    @(negedge clk);
    chk("stray_open", barreira, 1);
    for (int i = 0; i < 5; i++) begin
      dig_valid = 1'b1;
      dig = 4'hF;
      @(negedge clk);
    end
    dig_valid = 1'b0;
    car_passed = 1'b1;
    @(negedge clk);
    car_passed = 1'b0;
    chk("stray_occ", ocupacao, 1);
    send(24'h34A366, 3'd2);
    @(negedge clk);
    chk("stray_ignored", barreira, 1);
    car_passed = 1'b1;
    car_exit = 1'b1;
    @(negedge clk);
    car_passed = 1'b0;
    car_exit = 1'b0;
    chk("net_zero_occ", ocupacao, 1);
    chk("net_zero_bar", barreira, 0);
    for (int i = 0; i < 7; i++) admit_pass();
    chk("full_occ", ocupacao, 8);
    chk("full_cheio", cheio, 1);
    send(24'h34A366, 3'd7);
    expect_reject("full", 1);
    chk("full_hold", ocupacao, 8);
    for (int i = 0; i < 8; i++) begin
      car_exit = 1'b1;
      @(negedge clk);
    end
    car_exit = 1'b0;
    chk("empty_occ", ocupacao, 0);
    chk("empty_cheio", cheio, 0);
    car_exit = 1'b1;
    @(negedge clk);
    car_exit = 1'b0;
    chk("exit_at_zero", ocupacao, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
